// File: rtl/cpu_reg_file.sv
// Operand register file for the 8-bit ALU: two async read ports, one sync write port,
// {c,z,n} status flags and 16-bit register-pair inc/dec. Optional macro: REGFILE_BYPASS_EN.
module cpu_reg_file #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra_addr,
  output logic [7:0]    ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [7:0]    rb_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    wd,
  input  logic [2:0]    flag_we,
  input  logic [2:0]    flag_in,
  output logic [2:0]    flags,
  input  logic [1:0]    pair_op,
  input  logic [AW-2:0] pair_sel,
  output logic [15:0]   pair_data,
  output logic          pair_wrap
);

  logic [7:0]    regs_q [NREGS];
  logic [7:0]    regs_d [NREGS];
  logic [2:0]    flags_q, flags_d;
  logic          pair_wrap_q;

  logic [AW-1:0] lo_idx, hi_idx;
  logic [15:0]   pair_cur, pair_nxt;
  logic          pair_inc, pair_dec, pair_act, wrap_d;
  logic          collide, write_ok;

  assign lo_idx   = {pair_sel, 1'b0};
  assign hi_idx   = {pair_sel, 1'b1};
  assign pair_cur = {regs_q[hi_idx], regs_q[lo_idx]};
  assign pair_inc = (pair_op == 2'b01);
  assign pair_dec = (pair_op == 2'b10);
  assign pair_act = pair_inc | pair_dec;
  assign pair_nxt = pair_inc ? pair_cur + 16'd1 : pair_cur - 16'd1;
  assign wrap_d   = (pair_inc && (pair_cur == 16'hFFFF)) ||
                    (pair_dec && (pair_cur == 16'h0000));

  // A byte write into the active pair loses to the pair update.
  assign collide  = we && pair_act && (wa[AW-1:1] == pair_sel);
  assign write_ok = we && !collide;

  always_comb begin
    regs_d = regs_q;
    if (write_ok) begin
      regs_d[wa] = wd;
    end
    if (pair_act) begin
      regs_d[lo_idx] = pair_nxt[7:0];
      regs_d[hi_idx] = pair_nxt[15:8];
    end
  end

  assign flags_d = (flag_in & flag_we) | (flags_q & ~flag_we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= 8'h00;
      end
      flags_q     <= 3'b000;
      pair_wrap_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      flags_q     <= flags_d;
      pair_wrap_q <= wrap_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign ra_data = (write_ok && (ra_addr == wa)) ? wd : regs_q[ra_addr];
  assign rb_data = (write_ok && (rb_addr == wa)) ? wd : regs_q[rb_addr];
  assign flags   = flags_d;
`else
  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];
  assign flags   = flags_q;
`endif

  assign pair_data = pair_cur;
  assign pair_wrap = pair_wrap_q;

endmodule

// File: tb/tb_cpu_reg_file.sv
// Scoreboard bench for cpu_reg_file: random and directed stimulus against a byte-array model.
module tb_cpu_reg_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ra_addr = '0, rb_addr = '0, wa = '0;
  logic [7:0]  ra_data, rb_data, wd = '0;
  logic        we = 1'b0;
  logic [2:0]  flag_we = '0, flag_in = '0, flags;
  logic [1:0]  pair_op = '0;
  logic [2:0]  pair_sel = '0;
  logic [15:0] pair_data;
  logic        pair_wrap;

  cpu_reg_file #(.NREGS(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ra_addr(ra_addr), .ra_data(ra_data),
    .rb_addr(rb_addr), .rb_data(rb_data),
    .we(we), .wa(wa), .wd(wd),
    .flag_we(flag_we), .flag_in(flag_in), .flags(flags),
    .pair_op(pair_op), .pair_sel(pair_sel),
    .pair_data(pair_data), .pair_wrap(pair_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  mask;  // {wrap, flags, pair, rb, ra}
    logic [7:0]  ra, rb;
    logic [15:0] pd;
    logic [2:0]  fl;
    logic        wrap;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state
  logic [7:0] m_r [16];
  logic [2:0] m_fl;
  logic       m_wrap;

  function automatic bit collides(logic w, logic [3:0] a, logic [1:0] op, logic [2:0] p);
    return w && (op == 2'd1 || op == 2'd2) && (int'(a) / 2 == int'(p));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 8'h00;
    m_fl = 3'b000;
    m_wrap = 1'b0;
  endtask

  // Apply one clock edge of the current inputs to the model.
  task automatic model_edge();
    int v, nv, p;
    p = int'(pair_sel);
    v = int'(m_r[2*p+1]) * 256 + int'(m_r[2*p]);
    if (we && !collides(we, wa, pair_op, pair_sel)) m_r[wa] = wd;
    m_wrap = 1'b0;
    if (pair_op == 2'd1 || pair_op == 2'd2) begin
      if (pair_op == 2'd1) begin
        nv = (v + 1) % 65536;
        m_wrap = (v == 65535);
      end else begin
        nv = (v + 65535) % 65536;
        m_wrap = (v == 0);
      end
      m_r[2*p]   = 8'(nv % 256);
      m_r[2*p+1] = 8'(nv / 256);
    end
    for (int i = 0; i < 3; i++) if (flag_we[i]) m_fl[i] = flag_in[i];
  endtask

  task automatic drive(input logic w, input logic [3:0] a, input logic [7:0] d,
                       input logic [2:0] fwe, input logic [2:0] fin, input logic [1:0] op,
                       input logic [2:0] p, input logic [3:0] raa, input logic [3:0] rba);
    exp_t e;
    we = w; wa = a; wd = d; flag_we = fwe; flag_in = fin;
    pair_op = op; pair_sel = p; ra_addr = raa; rb_addr = rba;
    e.name = "model";
    e.mask = 5'b11111;
    e.ra = m_r[raa];
    e.rb = m_r[rba];
    e.fl = m_fl;
`ifdef REGFILE_BYPASS_EN
    if (w && !collides(w, a, op, p) && raa == a) e.ra = d;
    if (w && !collides(w, a, op, p) && rba == a) e.rb = d;
    for (int i = 0; i < 3; i++) if (fwe[i]) e.fl[i] = fin[i];
`endif
    e.pd = {m_r[2*int'(p)+1], m_r[2*int'(p)]};
    e.wrap = rst_n ? m_wrap : 1'b0;
    q.push_back(e);
  endtask

  task automatic expect_const(input string n, input logic [4:0] m, input logic [7:0] ra,
                              input logic [7:0] rb, input logic [15:0] pd,
                              input logic [2:0] fl, input logic wr);
    exp_t e;
    e.name = n; e.mask = m; e.ra = ra; e.rb = rb; e.pd = pd; e.fl = fl; e.wrap = wr;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic idle(input logic [2:0] p, input logic [3:0] raa, input logic [3:0] rba);
    drive(1'b0, 4'd0, 8'h00, 3'b000, 3'b000, 2'd0, p, raa, rba);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    drive(1'b1, a, d, 3'b000, 3'b000, 2'd0, 3'd0, a, a);
    tick();
  endtask

  // Monitor: every cycle the outputs are presented mid-cycle, away from the edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.mask[0]) begin
        checks++;
        if (ra_data !== e.ra) begin
          errors++;
          $display("FAIL %s ra_data got %h exp %h @%0t", e.name, ra_data, e.ra, $time);
        end
      end
      if (e.mask[1]) begin
        checks++;
        if (rb_data !== e.rb) begin
          errors++;
          $display("FAIL %s rb_data got %h exp %h @%0t", e.name, rb_data, e.rb, $time);
        end
      end
      if (e.mask[2]) begin
        checks++;
        if (pair_data !== e.pd) begin
          errors++;
          $display("FAIL %s pair_data got %h exp %h @%0t", e.name, pair_data, e.pd, $time);
        end
      end
      if (e.mask[3]) begin
        checks++;
        if (flags !== e.fl) begin
          errors++;
          $display("FAIL %s flags got %b exp %b @%0t", e.name, flags, e.fl, $time);
        end
      end
      if (e.mask[4]) begin
        checks++;
        if (pair_wrap !== e.wrap) begin
          errors++;
          $display("FAIL %s pair_wrap got %b exp %b @%0t", e.name, pair_wrap, e.wrap, $time);
        end
      end
    end
  end

  initial begin
    logic [7:0] rd;
    model_reset();
    #12 rst_n = 1'b1;
    tick();

    // Async reset, no clock edge between assertion and check
    drive(1'b1, 4'd5, 8'hA7, 3'b111, 3'b111, 2'd0, 3'd0, 4'd5, 4'd5);
    tick();
    idle(3'd2, 4'd5, 4'd5);
    expect_const("preload", 5'b01001, 8'hA7, 8'h00, 16'h0000, 3'b111, 1'b0);
    tick();
    #1 rst_n = 1'b0;
    model_reset();
    idle(3'd2, 4'd5, 4'd5);
    expect_const("reset", 5'b11111, 8'h00, 8'h00, 16'h0000, 3'b000, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Write/read, with and without forwarding
    drive(1'b1, 4'd3, 8'h5C, 3'b000, 3'b000, 2'd0, 3'd0, 4'd3, 4'd3);
`ifdef REGFILE_BYPASS_EN
    expect_const("wr_same", 5'b00011, 8'h5C, 8'h5C, 16'h0, 3'b0, 1'b0);
`else
    expect_const("wr_same", 5'b00011, 8'h00, 8'h00, 16'h0, 3'b0, 1'b0);
`endif
    tick();
    idle(3'd0, 4'd3, 4'd3);
    expect_const("wr_next", 5'b00011, 8'h5C, 8'h5C, 16'h0, 3'b0, 1'b0);
    tick();

    // Flags
    drive(1'b0, 4'd0, 8'h00, 3'b101, 3'b111, 2'd0, 3'd0, 4'd0, 4'd0);
    tick();
    drive(1'b0, 4'd0, 8'h00, 3'b000, 3'b000, 2'd0, 3'd0, 4'd0, 4'd0);
    expect_const("flags_set", 5'b01000, 8'h0, 8'h0, 16'h0, 3'b101, 1'b0);
    tick();
    idle(3'd0, 4'd0, 4'd0);
    expect_const("flags_hold", 5'b01000, 8'h0, 8'h0, 16'h0, 3'b101, 1'b0);
    tick();

    // Pair increment with wrap
    wr(4'd2, 8'hFF);
    wr(4'd3, 8'hFF);
    drive(1'b0, 4'd0, 8'h00, 3'b000, 3'b000, 2'd1, 3'd1, 4'd0, 4'd0);
    expect_const("inc_pre", 5'b00100, 8'h0, 8'h0, 16'hFFFF, 3'b0, 1'b0);
    tick();
    idle(3'd1, 4'd2, 4'd3);
    expect_const("inc_wrap", 5'b10111, 8'h00, 8'h00, 16'h0000, 3'b0, 1'b1);
    tick();
    drive(1'b0, 4'd0, 8'h00, 3'b000, 3'b000, 2'd1, 3'd1, 4'd0, 4'd0);
    tick();
    idle(3'd1, 4'd0, 4'd0);
    expect_const("inc_1", 5'b10100, 8'h0, 8'h0, 16'h0001, 3'b0, 1'b0);
    tick();
    wr(4'd2, 8'hFF);
    wr(4'd3, 8'h12);
    drive(1'b0, 4'd0, 8'h00, 3'b000, 3'b000, 2'd1, 3'd1, 4'd0, 4'd0);
    tick();
    idle(3'd1, 4'd0, 4'd0);
    expect_const("inc_carry", 5'b10100, 8'h0, 8'h0, 16'h1300, 3'b0, 1'b0);
    tick();

    // Pair decrement with wrap
    wr(4'd0, 8'h00);
    wr(4'd1, 8'h00);
    drive(1'b0, 4'd0, 8'h00, 3'b000, 3'b000, 2'd2, 3'd0, 4'd0, 4'd0);
    tick();
    idle(3'd0, 4'd0, 4'd1);
    expect_const("dec_wrap", 5'b10111, 8'hFF, 8'hFF, 16'hFFFF, 3'b0, 1'b1);
    tick();
    wr(4'd0, 8'h00);
    wr(4'd1, 8'h12);
    drive(1'b0, 4'd0, 8'h00, 3'b000, 3'b000, 2'd2, 3'd0, 4'd0, 4'd0);
    tick();
    idle(3'd0, 4'd0, 4'd0);
    expect_const("dec_borrow", 5'b10100, 8'h0, 8'h0, 16'h11FF, 3'b0, 1'b0);
    tick();

    // Collision: pair wins, forwarding suppressed
    wr(4'd4, 8'hFE);
    wr(4'd5, 8'h00);
    drive(1'b1, 4'd5, 8'h77, 3'b000, 3'b000, 2'd1, 3'd2, 4'd5, 4'd5);
    expect_const("coll_same", 5'b00001, 8'h00, 8'h0, 16'h0, 3'b0, 1'b0);
    tick();
    idle(3'd2, 4'd5, 4'd4);
    expect_const("coll_drop", 5'b00111, 8'h00, 8'hFF, 16'h00FF, 3'b0, 1'b0);
    tick();
    wr(4'd4, 8'hFE);
    wr(4'd5, 8'h00);
    wr(4'd6, 8'h00);
    drive(1'b1, 4'd6, 8'h77, 3'b000, 3'b000, 2'd1, 3'd2, 4'd6, 4'd6);
`ifdef REGFILE_BYPASS_EN
    expect_const("nocoll_same", 5'b00001, 8'h77, 8'h0, 16'h0, 3'b0, 1'b0);
`else
    expect_const("nocoll_same", 5'b00001, 8'h00, 8'h0, 16'h0, 3'b0, 1'b0);
`endif
    tick();
    idle(3'd2, 4'd6, 4'd6);
    expect_const("nocoll", 5'b00101, 8'h77, 8'h0, 16'h00FF, 3'b0, 1'b0);
    tick();

    // Random traffic; write data biased toward 00/FF so pair wraps occur
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0: rd = 8'h00;
        1: rd = 8'hFF;
        default: rd = 8'($urandom);
      endcase
      drive(1'($urandom), 4'($urandom), rd, 3'($urandom), 3'($urandom),
            2'($urandom), 3'($urandom), 4'($urandom), 4'($urandom));
      tick();
    end

    idle(3'd0, 4'd0, 4'd0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
